// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, per-cycle overflow/underflow pulses, a sticky error flag and optional FWFT read.
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       rd_en_i,
  input  logic                       clr_err_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       rvalid_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  output logic                       error_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q, af_q, ae_q;
  logic             ovf_q, unf_q, err_q;
  logic             wr_acc, rd_acc;

  assign wr_acc = wr_en_i && !full_q;
  assign rd_acc = rd_en_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_acc) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Flags are registered from count_d so they move on the same edge as count_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == '0);
      af_q    <= (count_d >= AF_C);
      ae_q    <= (count_d <= AE_C);
      ovf_q   <= wr_en_i && full_q;
      unf_q   <= rd_en_i && empty_q;
      if ((wr_en_i && full_q) || (rd_en_i && empty_q)) err_q <= 1'b1;
      else if (clr_err_i)                                err_q <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is forced to zero while empty so reset presents rdata_o = 0.
      assign rdata_o  = empty_q ? '0 : mem_q[rd_ptr_q];
      assign rvalid_o = !empty_q;
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q;
      logic             rvalid_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_acc;
          if (rd_acc) rdata_q <= mem_q[rd_ptr_q];
        end
      end
      assign rdata_o  = rdata_q;
      assign rvalid_o = rvalid_q;
    end
  endgenerate

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
  assign error_o        = err_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-read and an FWFT instance share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_sync_fifo_flags;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, wr_en, rd_en, clr_err;
  logic [W-1:0] wdata;

  logic [W-1:0] s_rdata, f_rdata;
  logic         s_rvalid, f_rvalid;
  logic         s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_err;
  logic         f_full, f_empty, f_af, f_ae, f_ovf, f_unf, f_err;
  logic [4:0]   s_count, f_count;

  sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
    .clr_err_i(clr_err), .rdata_o(s_rdata), .rvalid_o(s_rvalid), .full_o(s_full),
    .empty_o(s_empty), .almost_full_o(s_af), .almost_empty_o(s_ae), .count_o(s_count),
    .overflow_o(s_ovf), .underflow_o(s_unf), .error_o(s_err));

  sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
    .clr_err_i(clr_err), .rdata_o(f_rdata), .rvalid_o(f_rvalid), .full_o(f_full),
    .empty_o(f_empty), .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_count),
    .overflow_o(f_ovf), .underflow_o(f_unf), .error_o(f_err));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [W-1:0] q[$];
  logic         m_ovf = 1'b0, m_unf = 1'b0, m_err = 1'b0, m_rv = 1'b0;
  logic [W-1:0] m_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int unsigned n;
    n = q.size();
    check("count",     32'(s_count),  32'(n));
    check("full",      32'(s_full),   32'(n == D));
    check("empty",     32'(s_empty),  32'(n == 0));
    check("almost_full",  32'(s_af),  32'(n >= AF));
    check("almost_empty", 32'(s_ae),  32'(n <= AE));
    check("overflow",  32'(s_ovf),    32'(m_ovf));
    check("underflow", 32'(s_unf),    32'(m_unf));
    check("error",     32'(s_err),    32'(m_err));
    check("rvalid",    32'(s_rvalid), 32'(m_rv));
    check("rdata",     32'(s_rdata),  32'(m_rdata));
    check("fwft_count",  32'(f_count),  32'(n));
    check("fwft_rvalid", 32'(f_rvalid), 32'(n != 0));
    check("fwft_rdata",  32'(f_rdata),  (n != 0) ? 32'(q[0]) : 32'h0);
  endtask

  // One clock: apply inputs, advance model on the edge, compare just after it.
  task automatic step(input logic r, input logic w, input logic [W-1:0] d,
                      input logic rd, input logic c);
    logic was_full, was_empty;
    rst = r; wr_en = w; wdata = d; rd_en = rd; clr_err = c;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0; m_rv = 1'b0; m_rdata = '0;
    end else begin
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      m_ovf = w && was_full;
      m_unf = rd && was_empty;
      m_rv  = rd && !was_empty;
      if (m_rv) m_rdata = q.pop_front();
      if (w && !was_full) q.push_back(d);
      if (m_ovf || m_unf) m_err = 1'b1;
      else if (c)         m_err = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wdata = '0;
    step(1, 0, 8'h00, 0, 0);
    step(1, 1, 8'h77, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Fill 0x00..0x0F, then overflow with 0xAA, then clear the error
    for (int i = 0; i < D; i++) step(0, 1, 8'(i), 0, 0);
    step(0, 1, 8'hAA, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 1);

    // Drain back-to-back, then underflow
    for (int i = 0; i < D; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 1);   // set and clear together: set wins
    step(0, 0, 8'h00, 0, 1);

    // Write 10, read 10, then stream at count 5 across pointer wrap
    for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h20 + i), 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++)  step(0, 1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 8'(8'h50 + i), 1, 0);

    // Full with read+write, then empty with read+write
    while (q.size() < D) step(0, 1, 8'($urandom), 0, 0);
    step(0, 1, 8'hBB, 1, 0);
    while (q.size() > 0) step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'hC3, 1, 0);
    step(0, 0, 8'h00, 1, 1);

    // FWFT head visibility after write to empty FIFO
    step(0, 1, 8'h5A, 0, 0);
    step(0, 0, 8'h00, 1, 0);

    // Randomised traffic with varying bias
    for (int i = 0; i < 600; i++) begin
      int unsigned wp;
      wp = (i < 200) ? 70 : (i < 400) ? 30 : 50;
      step(0, $urandom_range(0, 99) < wp, 8'($urandom),
           $urandom_range(0, 99) < (100 - wp), $urandom_range(0, 9) == 0);
    end

    // Reset at count 7 together with a write, then reuse
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 8'(8'h90 + i), 0, 0);
    step(0, 1, 8'h11, 1, 0);
    step(1, 1, 8'hEE, 0, 0);
    step(0, 1, 8'h3C, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
